dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Data-memory bridge between the MIPS CPU MEM stage and the data memory. It converts a one-cycle MEM-stage load/store into a req/gnt/rvalid transaction on the memory side and holds the pipeline with `stallM` until the access completes. It also performs sub-word lane steering, byte-enable generation, load sign/zero extension and alignment checking.

## Interface
Parameters:
- `ADDR_W`, 32: address width on both sides.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `memreadM`  in  1: MEM-stage load.
- `memwriteM`  in  1: MEM-stage store; has priority if both are high.
- `aluoutM`  in  ADDR_W: byte address.
- `writedataM`  in  32: store data, right-aligned.
- `mem_opM`  in  3: access size.
  - 000: word.
  - 001: half, signed.
  - 010: half, unsigned.
  - 011: byte, signed.
  - 100: byte, unsigned.
  - 101–111: treated as word.
- `readdataM`  out  32: formatted load data; valid while `stallM`=0 in DONE.
- `stallM`  out  1: hold the pipeline.
- `adelM`  out  1: load address error pulse.
- `adesM`  out  1: store address error pulse.
- `mem_req`  out  1: memory request.
- `mem_we`  out  1: 1 = write.
- `mem_addr`  out  ADDR_W: word-aligned address (bits [1:0]=00).
- `mem_be`  out  4: byte enables, little-endian lanes.
- `mem_wdata`  out  32: lane-steered store data.
- `mem_gnt`  in  1: request accepted this cycle.
- `mem_rvalid`  in  1: read data valid.
- `mem_rdata`  in  32: read data.

## Operation
- FSM states: IDLE, REQ, WAIT_R, DONE.
- **IDLE**
  - Access present and aligned: latch addr, size, data and direction; assert `stallM` combinationally; go to REQ.
  - Misaligned (word with addr[1:0]≠0, half with addr[0]≠0): no request; pulse `adesM` (store) or `adelM` (load) combinationally; `stallM`=0; stay IDLE.
  - No access: `stallM`=0.
- **REQ**: `mem_req`=1 from latched fields, `stallM`=1.
  - `mem_gnt`=1 and store: go to DONE.
  - `mem_gnt`=1 and load: go to WAIT_R.
  - Otherwise hold with all memory outputs stable.
- **WAIT_R**: `mem_req`=0, `stallM`=1. When `mem_rvalid`=1, register the formatted data into `readdataM` and go to DONE.
- **DONE**: `stallM`=0 so the pipeline advances at this edge; inputs are not sampled; next state is IDLE.
- Store formatting:
  - sb: `mem_wdata`={4{byte}}, `mem_be`=1<<addr[1:0].
  - sh: `mem_wdata`={2{half}}, `mem_be`=addr[1]?1100:0011.
  - sw: `mem_be`=1111.
- Load formatting:
  - Byte: lane = addr[1:0].
  - Half: lane = addr[1].
  - Signed ops sign-extend to 32 bits; unsigned ops zero-extend.
- `mem_be`=1111 for loads.
- `mem_rvalid` outside WAIT_R is ignored.

## Timing
- Reset values: all outputs 0, state IDLE.
- Reset is asynchronous: asserting it mid-transaction drops `mem_req` and `stallM` immediately. An `mem_rvalid` arriving after reset is ignored.
- Load, with gnt in the first REQ cycle and rvalid one cycle later: 3 stall cycles (IDLE, REQ, WAIT_R), released in the 4th (DONE).
- Store, with immediate gnt: 2 stall cycles (IDLE, REQ), released in DONE.
- Each REQ cycle without `mem_gnt` adds one stall cycle; each WAIT_R cycle without `mem_rvalid` adds one stall cycle.
- `mem_rvalid` is never expected in the same cycle as `mem_gnt`.
- Back-to-back accesses: the second is sampled in the IDLE cycle right after DONE.
- `readdataM` holds its value until the next load completes.

## Configuration
- `DMEM_SUBWORD_EN` defined: full sub-word behaviour as above.
- Undefined:
  - `mem_opM` is ignored and every access is word size.
  - `mem_be`=1111 and `mem_wdata`=`writedataM`.
  - Loads return the raw `mem_rdata`.
  - Only the addr[1:0]≠0 alignment check remains.

## Test plan
- lw from 0x10 with `mem_rdata`=0xDEADBEEF, gnt immediate, rvalid next cycle → `stallM` high for 3 cycles, then `readdataM`=0xDEADBEEF with `stallM`=0.
- sb 0xA5 to 0x13 → `mem_addr`=0x10, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `mem_we`=1; 2 stall cycles.
- lb and lbu from 0x12 with `mem_rdata`=0x00800000 → 0xFFFFFF80 and 0x00000080 respectively.
- lw from 0x06 → `adelM` pulse, `mem_req` stays 0, no stall. sh to 0x05 → `adesM` pulse.
- `mem_gnt` held low for 3 cycles during a store → `mem_req`, `mem_addr` and `mem_wdata` stable; stall lasts 5 cycles total.
- `rst` asserted in WAIT_R, then `mem_rvalid` arrives → outputs immediately 0, state IDLE, `readdataM` remains 0.

Source files
------------

// File: rtl/dmem_bridge.sv
// dmem_bridge: MIPS MEM-stage to data-memory bridge.
// Turns a single-cycle load/store into a req/gnt/rvalid transaction, stalls the
// pipeline until it completes, and handles lane steering, byte enables, load
// extension and alignment checks.
// Optional feature: define DMEM_SUBWORD_EN for byte/half accesses; without it
// every access is a full word and mem_opM is ignored.
module dmem_bridge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  input  logic              memreadM,
  input  logic              memwriteM,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [31:0]       writedataM,
  input  logic [2:0]        mem_opM,
  output logic [31:0]       readdataM,
  output logic              stallM,
  output logic              adelM,
  output logic              adesM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE}       size_t;

  state_t              state_q;
  size_t               size_q;
  logic                sext_q;
  logic [1:0]          lane_q;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [3:0]          mem_be_q;
  logic [31:0]         mem_wdata_q;
  logic [31:0]         readdata_q;

  size_t               size_d;
  logic                sext_d;
  logic [3:0]          be_d;
  logic [31:0]         wdata_d;
  logic [31:0]         load_d;
  logic                access, misaligned, start;

`ifdef DMEM_SUBWORD_EN
  // Decode the access size and extension mode of the incoming request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    size_d = SZ_WORD;
    sext_d = 1'b0;
    case (mem_opM)
      3'b001:  begin size_d = SZ_HALF; sext_d = 1'b1; end
      3'b010:  begin size_d = SZ_HALF; sext_d = 1'b0; end
      3'b011:  begin size_d = SZ_BYTE; sext_d = 1'b1; end
      3'b100:  begin size_d = SZ_BYTE; sext_d = 1'b0; end
      default: ;
    endcase
  end

  // Steer store data onto its byte lanes and build the byte enables.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = writedataM;
    if (memwriteM) begin
      case (size_d)
        SZ_BYTE: begin
          wdata_d = {4{writedataM[7:0]}};
          be_d    = 4'b0001 << aluoutM[1:0];
        end
        SZ_HALF: begin
          wdata_d = {2{writedataM[15:0]}};
          be_d    = aluoutM[1] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end
  end

  // Pick the addressed lane of the read data and extend it to 32 bits.
  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    case (lane_q)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SZ_BYTE: load_d = {{24{sext_q & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_d = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_d = mem_rdata;
    endcase
  end
`else
  // Word-only build: size fields are constant and the data passes straight through.
  logic unused_fields;
  assign size_d        = SZ_WORD;
  assign sext_d        = 1'b0;
  assign be_d          = 4'b1111;
  assign wdata_d       = writedataM;
  assign load_d        = mem_rdata;
  assign unused_fields = ^{mem_opM, size_q, sext_q, lane_q};
`endif

  assign access     = memreadM | memwriteM;
  assign misaligned = ((size_d == SZ_WORD) && (aluoutM[1:0] != 2'b00)) ||
                      ((size_d == SZ_HALF) && aluoutM[0]);
  assign start      = (state_q == S_IDLE) && access && !misaligned;

  // Stall and error pulses are combinational in IDLE; gating with rst drops them during reset.
  assign stallM = rst & (start || (state_q == S_REQ) || (state_q == S_WAIT_R));
  assign adelM  = rst & (state_q == S_IDLE) & access & misaligned & ~memwriteM;
  assign adesM  = rst & (state_q == S_IDLE) & access & misaligned &  memwriteM;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign readdataM = readdata_q;

  // Transaction FSM: latches the request, drives the memory side, captures load data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      size_q      <= SZ_WORD;
      sext_q      <= 1'b0;
      lane_q      <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      readdata_q  <= 32'h0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= memwriteM;
            mem_addr_q  <= {aluoutM[ADDR_W-1:2], 2'b00};
            mem_be_q    <= be_d;
            mem_wdata_q <= wdata_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            lane_q      <= aluoutM[1:0];
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= mem_we_q ? S_DONE : S_WAIT_R;
          end
        end
        S_WAIT_R: begin
          if (mem_rvalid) begin
            readdata_q <= load_d;
            state_q    <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed, table-driven bench for dmem_bridge.
// Expected values follow the build: sub-word results when DMEM_SUBWORD_EN is
// defined, word-only results otherwise.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        memreadM, memwriteM;
  logic [31:0] aluoutM, writedataM;
  logic [2:0]  mem_opM;
  logic [31:0] readdataM;
  logic        stallM, adelM, adesM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rd;

  dmem_bridge #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .memreadM(memreadM), .memwriteM(memwriteM), .aluoutM(aluoutM),
    .writedataM(writedataM), .mem_opM(mem_opM),
    .readdataM(readdataM), .stallM(stallM), .adelM(adelM), .adesM(adesM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        re, we;
    logic [31:0] addr, wdata;
    logic [2:0]  op;
    logic [31:0] rdata;
    int          gnt_wait, rv_wait;
    logic        mis;
    int          stall;
    logic [3:0]  be;
    logic [31:0] wd, rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic re, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] op,
                              input logic [31:0] rdata, input int gnt_wait, input int rv_wait,
                              input logic mis, input int stall, input logic [3:0] be,
                              input logic [31:0] wd, input logic [31:0] rd);
    vec_t v;
    v.re = re; v.we = we; v.addr = addr; v.wdata = wdata; v.op = op; v.rdata = rdata;
    v.gnt_wait = gnt_wait; v.rv_wait = rv_wait; v.mis = mis; v.stall = stall;
    v.be = be; v.wd = wd; v.rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    memreadM = 1'b0; memwriteM = 1'b0; aluoutM = 32'h0; writedataM = 32'h0;
    mem_opM = 3'b000; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
  endtask

  // Applies one vector starting right after a rising edge; returns right after a rising edge.
  task automatic run_vec(input int idx, input vec_t v);
    int  stalls, req_cycles, rv_cycles;
    bit  granted, done;
    memreadM = v.re; memwriteM = v.we; aluoutM = v.addr; writedataM = v.wdata;
    mem_opM = v.op; mem_rdata = v.rdata;
    if (v.mis) begin
      @(negedge clk);
      check($sformatf("v%0d adelM", idx), 32'(adelM), 32'(v.re & ~v.we));
      check($sformatf("v%0d adesM", idx), 32'(adesM), 32'(v.we));
      check($sformatf("v%0d stallM", idx), 32'(stallM), 32'h0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check($sformatf("v%0d no req", idx), 32'(mem_req), 32'h0);
      check($sformatf("v%0d adel clear", idx), 32'(adelM | adesM), 32'h0);
      check($sformatf("v%0d readdata held", idx), readdataM, last_rd);
      @(posedge clk); #1;
    end else begin
      stalls = 0; req_cycles = 0; rv_cycles = 0; granted = 0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        if (!stallM) begin
          done = 1;
        end else begin
          stalls++;
          if (mem_req) begin
            check($sformatf("v%0d mem_addr", idx), mem_addr, v.addr & 32'hFFFF_FFFC);
            check($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.we));
            check($sformatf("v%0d mem_be", idx), 32'(mem_be), 32'(v.be));
            if (v.we) check($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wd);
            if (req_cycles == v.gnt_wait) begin
              mem_gnt = 1'b1;
              granted = 1;
            end
            req_cycles++;
          end else if (granted && !v.we) begin
            if (rv_cycles == v.rv_wait) mem_rvalid = 1'b1;
            rv_cycles++;
          end
          @(posedge clk); #1;
          mem_gnt = 1'b0; mem_rvalid = 1'b0;
        end
      end
      check($sformatf("v%0d completed", idx), 32'(done), 32'h1);
      check($sformatf("v%0d stall cycles", idx), 32'(stalls), 32'(v.stall));
      check($sformatf("v%0d req seen", idx), 32'(req_cycles), 32'(v.gnt_wait + 1));
      if (!v.we) last_rd = v.rd;
      check($sformatf("v%0d readdataM", idx), readdataM, last_rd);
      check($sformatf("v%0d no addr err", idx), 32'(adelM | adesM), 32'h0);
      @(posedge clk); #1;
      idle_inputs();
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b0;
    idle_inputs();
    last_rd = 32'h0;

    // Reset values.
    #12;
    check("reset readdataM", readdataM, 32'h0);
    check("reset stallM", 32'(stallM), 32'h0);
    check("reset mem_req", 32'(mem_req), 32'h0);
    check("reset mem_we", 32'(mem_we), 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_be", 32'(mem_be), 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);
    check("reset addr errs", 32'(adelM | adesM), 32'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Reset in WAIT_R: outputs drop at once and a late rvalid is ignored.
    memreadM = 1'b1; aluoutM = 32'h40; mem_opM = 3'b000;
    @(negedge clk);
    check("rst seq stall idle", 32'(stallM), 32'h1);
    @(posedge clk); #1;
    cyc = 0;
    while (!mem_req && cyc < 10) begin @(posedge clk); #1; cyc++; end
    check("rst seq req", 32'(mem_req), 32'h1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    check("rst seq wait stall", 32'(stallM), 32'h1);
    check("rst seq wait req", 32'(mem_req), 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("rst async stall", 32'(stallM), 32'h0);
    check("rst async req", 32'(mem_req), 32'h0);
    check("rst async readdata", readdataM, 32'h0);
    memreadM = 1'b0;
    @(negedge clk); rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("late rvalid readdata", readdataM, 32'h0);
    check("late rvalid stall", 32'(stallM), 32'h0);
    check("late rvalid req", 32'(mem_req), 32'h0);
    @(posedge clk); #1;
    idle_inputs();

    // re, we, addr, wdata, op, rdata, gnt_wait, rv_wait, mis, stall, be, wd, rd
    vecs.push_back(mk(1, 0, 32'h10, 32'h0, 3'b000, 32'hDEADBEEF, 0, 0, 0, 3, 4'hF, 32'h0, 32'hDEADBEEF));
`ifdef DMEM_SUBWORD_EN
    vecs.push_back(mk(0, 1, 32'h13, 32'hA5, 3'b011, 32'h0, 0, 0, 0, 2, 4'b1000, 32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk(1, 0, 32'h12, 32'h0, 3'b011, 32'h00800000, 0, 0, 0, 3, 4'hF, 32'h0, 32'hFFFFFF80));
    vecs.push_back(mk(1, 0, 32'h12, 32'h0, 3'b100, 32'h00800000, 0, 0, 0, 3, 4'hF, 32'h0, 32'h00000080));
`else
    vecs.push_back(mk(0, 1, 32'h13, 32'hA5, 3'b011, 32'h0, 0, 0, 1, 0, 4'hF, 32'h0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h12, 32'h0, 3'b011, 32'h00800000, 0, 0, 1, 0, 4'hF, 32'h0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h12, 32'h0, 3'b100, 32'h00800000, 0, 0, 1, 0, 4'hF, 32'h0, 32'h0));
`endif
    vecs.push_back(mk(1, 0, 32'h06, 32'h0, 3'b000, 32'h0, 0, 0, 1, 0, 4'hF, 32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h05, 32'h1234, 3'b001, 32'h0, 0, 0, 1, 0, 4'hF, 32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h20, 32'h12345678, 3'b000, 32'h0, 3, 0, 0, 5, 4'hF, 32'h12345678, 32'h0));
`ifdef DMEM_SUBWORD_EN
    vecs.push_back(mk(1, 0, 32'h24, 32'h0, 3'b001, 32'h00008000, 0, 0, 0, 3, 4'hF, 32'h0, 32'hFFFF8000));
    vecs.push_back(mk(0, 1, 32'h28, 32'h1C3, 3'b011, 32'h0, 0, 0, 0, 2, 4'b0001, 32'hC3C3C3C3, 32'h0));
    vecs.push_back(mk(1, 0, 32'h2E, 32'h0, 3'b010, 32'hABCD1234, 0, 0, 0, 3, 4'hF, 32'h0, 32'h0000ABCD));
    vecs.push_back(mk(0, 1, 32'h36, 32'hBEEF, 3'b001, 32'h0, 0, 0, 0, 2, 4'b1100, 32'hBEEFBEEF, 32'h0));
    vecs.push_back(mk(1, 0, 32'h11, 32'h0, 3'b011, 32'h00007F00, 1, 0, 0, 4, 4'hF, 32'h0, 32'h0000007F));
`else
    vecs.push_back(mk(1, 0, 32'h24, 32'h0, 3'b001, 32'h00008000, 0, 0, 0, 3, 4'hF, 32'h0, 32'h00008000));
    vecs.push_back(mk(0, 1, 32'h28, 32'h1C3, 3'b011, 32'h0, 0, 0, 0, 2, 4'hF, 32'h000001C3, 32'h0));
    vecs.push_back(mk(1, 0, 32'h2E, 32'h0, 3'b010, 32'hABCD1234, 0, 0, 1, 0, 4'hF, 32'h0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h36, 32'hBEEF, 3'b001, 32'h0, 0, 0, 1, 0, 4'hF, 32'h0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h11, 32'h0, 3'b011, 32'h00007F00, 1, 0, 1, 0, 4'hF, 32'h0, 32'h0));
`endif
    vecs.push_back(mk(1, 0, 32'h30, 32'h0, 3'b111, 32'h0F0FF0F0, 0, 2, 0, 5, 4'hF, 32'h0, 32'h0F0FF0F0));
    vecs.push_back(mk(1, 1, 32'h34, 32'hCAFEF00D, 3'b000, 32'h0, 0, 0, 0, 2, 4'hF, 32'hCAFEF00D, 32'h0));
    vecs.push_back(mk(1, 0, 32'h38, 32'h0, 3'b000, 32'h89ABCDEF, 1, 1, 0, 5, 4'hF, 32'h0, 32'h89ABCDEF));

    // Vectors run back to back: each new access is applied in the IDLE cycle after DONE.
    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    @(negedge clk);
    check("final idle stall", 32'(stallM), 32'h0);
    check("final readdata held", readdataM, last_rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
